// File: rtl/slice_sequencer.sv
// Slice cutting sequencer: takes an ultrasonic reference reading, feeds material
// until the measured travel reaches the slice thickness, cuts, and repeats.
module slice_sequencer #(
  parameter int DIST_W    = 32,
  parameter int NUM_W     = 5,
  parameter int TIMEOUT   = 50000,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  input  logic [NUM_W-1:0]  slice_num,
  input  logic [DIST_W-1:0] thickness,
  input  logic              valid,
  input  logic [DIST_W-1:0] distance,
  input  logic              trigger_suc,
  output logic              trigger,
  output logic              move,
  input  logic              cut_end,
  output logic              cut,
  output logic              finish,
  output logic              error,
  output logic              busy,
  output logic [NUM_W-1:0]  slices_done
);

  localparam int CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    EVAL,
    CUT,
    DONE,
    ERR
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [DIST_W-1:0]   ref_dist_q, ref_dist_d;
  logic [DIST_W-1:0]   dist_q, dist_d;
  logic [DIST_W-1:0]   thick_q, thick_d;
  logic [NUM_W-1:0]    num_q, num_d;
  logic [NUM_W-1:0]    done_q, done_d;
  logic                ref_phase_q, ref_phase_d;
  logic                zero_fin_q, zero_fin_d;

  logic [DIST_W-1:0]   diff;
  logic [NUM_W-1:0]    done_inc;
  logic                timeout;

  assign diff        = (ref_dist_q >= dist_q) ? (ref_dist_q - dist_q) : '0;
  assign done_inc    = done_q + 1'b1;
  assign timeout     = (cnt_q == CNT_LAST);
  assign slices_done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      retry_q     <= '0;
      ref_dist_q  <= '0;
      dist_q      <= '0;
      thick_q     <= '0;
      num_q       <= '0;
      done_q      <= '0;
      ref_phase_q <= 1'b0;
      zero_fin_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      ref_dist_q  <= ref_dist_d;
      dist_q      <= dist_d;
      thick_q     <= thick_d;
      num_q       <= num_d;
      done_q      <= done_d;
      ref_phase_q <= ref_phase_d;
      zero_fin_q  <= zero_fin_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    ref_dist_d  = ref_dist_q;
    dist_d      = dist_q;
    thick_d     = thick_q;
    num_d       = num_q;
    done_d      = done_q;
    ref_phase_d = ref_phase_q;
    zero_fin_d  = 1'b0;

    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, ERR: begin
          if (start) begin
            if (slice_num != '0) begin
              num_d       = slice_num;
              thick_d     = thickness;
              done_d      = '0;
              retry_d     = '0;
              ref_phase_d = 1'b1;
              cnt_d       = '0;
              state_d     = TRIG;
            end else begin
              zero_fin_d = 1'b1;
              state_d    = IDLE;
            end
          end
        end
        TRIG: begin
          if (!pause) begin
            if (trigger_suc) begin
              cnt_d   = '0;
              state_d = WAIT_ECHO;
            end else if (timeout) begin
              cnt_d = '0;
              if (retry_q == RETRY_MAX) begin
                state_d = ERR;
              end else begin
                retry_d = retry_q + 1'b1;
                state_d = TRIG;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        WAIT_ECHO: begin
          // valid is tested ahead of timeout so a late echo is never lost
          if (!pause) begin
            if (valid) begin
              dist_d  = distance;
              retry_d = '0;
              cnt_d   = '0;
              if (ref_phase_q) begin
                ref_dist_d  = distance;
                ref_phase_d = 1'b0;
                state_d     = TRIG;
              end else begin
                state_d = EVAL;
              end
            end else if (timeout) begin
              cnt_d = '0;
              if (retry_q == RETRY_MAX) begin
                state_d = ERR;
              end else begin
                retry_d = retry_q + 1'b1;
                state_d = TRIG;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        EVAL: begin
          if (!pause) begin
            cnt_d   = '0;
            state_d = (diff >= thick_q) ? CUT : TRIG;
          end
        end
        CUT: begin
          if (cut_end) begin
            ref_dist_d = dist_q;
            done_d     = done_inc;
            cnt_d      = '0;
            state_d    = (done_inc == num_q) ? DONE : TRIG;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    trigger = 1'b0;
    move    = 1'b0;
    cut     = 1'b0;
    finish  = zero_fin_q;
    error   = 1'b0;
    busy    = 1'b0;
    case (state_q)
      TRIG: begin
        busy    = 1'b1;
        trigger = !pause && !abort;
        move    = !pause && !abort && !ref_phase_q;
      end
      WAIT_ECHO, EVAL: begin
        busy = 1'b1;
        move = !pause && !abort && !ref_phase_q;
      end
      CUT: begin
        busy = 1'b1;
        cut  = !abort;
      end
      DONE: begin
        busy   = 1'b1;
        finish = !abort;
      end
      ERR: begin
        error = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_slice_sequencer.sv
// Directed bench for slice_sequencer: a per-cycle vector table for the main run
// and edge cases, then hand-written sequences for abort, timeout, pause and reset.
module tb_slice_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start, pause, abort, valid, trigger_suc, cut_end;
  logic [4:0]  slice_num;
  logic [31:0] thickness, distance;
  logic        trigger, move, cut, finish, error, busy;
  logic [4:0]  slices_done;

  int checks = 0;
  int passes = 0;

  slice_sequencer #(
    .DIST_W   (32),
    .NUM_W    (5),
    .TIMEOUT  (20),
    .MAX_RETRY(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pause      (pause),
    .abort      (abort),
    .slice_num  (slice_num),
    .thickness  (thickness),
    .valid      (valid),
    .distance   (distance),
    .trigger_suc(trigger_suc),
    .trigger    (trigger),
    .move       (move),
    .cut_end    (cut_end),
    .cut        (cut),
    .finish     (finish),
    .error      (error),
    .busy       (busy),
    .slices_done(slices_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        st, pa, ab, va, ts, ce;
    logic [4:0]  num;
    logic [31:0] th, d;
    logic [5:0]  o;   // {trigger, move, cut, finish, error, busy}
    logic [4:0]  sd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic pa, logic ab, logic va, logic ts, logic ce,
                              logic [4:0] num, logic [31:0] th, logic [31:0] d,
                              logic [5:0] o, logic [4:0] sd);
    vec_t v;
    v.st = st; v.pa = pa; v.ab = ab; v.va = va; v.ts = ts; v.ce = ce;
    v.num = num; v.th = th; v.d = d; v.o = o; v.sd = sd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Drive inputs just after the falling edge; outputs are then sampled 1 time unit later.
  task automatic apply(input logic st, input logic pa, input logic ab, input logic va,
                       input logic ts, input logic ce, input logic [31:0] d);
    @(negedge clk);
    start = st; pause = pa; abort = ab; valid = va; trigger_suc = ts; cut_end = ce;
    distance = d;
    #1;
  endtask

  function automatic logic [5:0] outs();
    return {trigger, move, cut, finish, error, busy};
  endfunction

  logic seen;
  logic bad;

  initial begin
    rst_n = 1'b0;
    start = 0; pause = 0; abort = 0; valid = 0; trigger_suc = 0; cut_end = 0;
    slice_num = '0; thickness = '0; distance = '0;

    // Normal run: 2 slices of 300 (900 ref; 800, 600 -> cut; 450, 280 -> cut)
    tbl.push_back(mk(1,0,0,0,0,0, 2,300,  0, 6'b000000, 0));
    tbl.push_back(mk(0,0,0,0,1,0, 2,300,  0, 6'b100001, 0));
    tbl.push_back(mk(0,0,0,1,0,0, 2,300,900, 6'b000001, 0));
    tbl.push_back(mk(0,0,0,0,1,0, 2,300,  0, 6'b110001, 0));
    tbl.push_back(mk(0,0,0,1,0,0, 2,300,800, 6'b010001, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 2,300,  0, 6'b010001, 0));
    tbl.push_back(mk(0,0,0,0,1,0, 2,300,  0, 6'b110001, 0));
    tbl.push_back(mk(0,0,0,1,0,0, 2,300,600, 6'b010001, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 2,300,  0, 6'b010001, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 2,300,  0, 6'b001001, 0));
    tbl.push_back(mk(0,0,0,0,0,1, 2,300,  0, 6'b001001, 0));
    tbl.push_back(mk(0,0,0,0,1,0, 2,300,  0, 6'b110001, 1));
    tbl.push_back(mk(0,0,0,1,0,0, 2,300,450, 6'b010001, 1));
    tbl.push_back(mk(0,0,0,0,0,0, 2,300,  0, 6'b010001, 1));
    tbl.push_back(mk(0,0,0,0,1,0, 2,300,  0, 6'b110001, 1));
    tbl.push_back(mk(0,0,0,1,0,0, 2,300,280, 6'b010001, 1));
    tbl.push_back(mk(0,0,0,0,0,0, 2,300,  0, 6'b010001, 1));
    tbl.push_back(mk(0,0,0,0,0,1, 2,300,  0, 6'b001001, 1));
    tbl.push_back(mk(0,0,0,0,0,0, 2,300,  0, 6'b000101, 2));
    tbl.push_back(mk(0,0,0,0,0,0, 2,300,  0, 6'b000000, 2));
    // slice_num = 0: finish one cycle after start, no trigger
    tbl.push_back(mk(1,0,0,0,0,0, 0,300,  0, 6'b000000, 2));
    tbl.push_back(mk(0,0,0,0,0,0, 0,300,  0, 6'b000100, 2));
    tbl.push_back(mk(0,0,0,0,0,0, 0,300,  0, 6'b000000, 2));
    // 950 after ref 900: diff clamps to 0, back to TRIG rather than CUT; then abort
    tbl.push_back(mk(1,0,0,0,0,0, 1, 10,  0, 6'b000000, 2));
    tbl.push_back(mk(0,0,0,0,1,0, 1, 10,  0, 6'b100001, 0));
    tbl.push_back(mk(0,0,0,1,0,0, 1, 10,900, 6'b000001, 0));
    tbl.push_back(mk(0,0,0,0,1,0, 1, 10,  0, 6'b110001, 0));
    tbl.push_back(mk(0,0,0,1,0,0, 1, 10,950, 6'b010001, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 1, 10,  0, 6'b010001, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 1, 10,  0, 6'b110001, 0));
    tbl.push_back(mk(0,0,1,0,0,0, 1, 10,  0, 6'b000001, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 1, 10,  0, 6'b000000, 0));

    #3;
    chk("reset_outs", 32'(outs()), 0);
    chk("reset_sd", 32'(slices_done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      slice_num = tbl[i].num;
      thickness = tbl[i].th;
      apply(tbl[i].st, tbl[i].pa, tbl[i].ab, tbl[i].va, tbl[i].ts, tbl[i].ce, tbl[i].d);
      chk($sformatf("vec%0d.outs", i), 32'(outs()), 32'(tbl[i].o));
      chk($sformatf("vec%0d.sd", i), 32'(slices_done), 32'(tbl[i].sd));
    end

    // Abort during second CUT of a 3-slice job
    slice_num = 5'd3; thickness = 32'd100;
    apply(1,0,0,0,0,0,  0);
    apply(0,0,0,0,1,0,  0);
    apply(0,0,0,1,0,0,900);
    apply(0,0,0,0,1,0,  0);
    apply(0,0,0,1,0,0,700);
    apply(0,0,0,0,0,0,  0);
    apply(0,0,0,0,0,1,  0);
    chk("abort.first_cut", 32'(cut), 1);
    apply(0,0,0,0,1,0,  0);
    apply(0,0,0,1,0,0,500);
    apply(0,0,0,0,0,0,  0);
    apply(0,0,0,0,0,0,  0);
    chk("abort.in_cut", 32'(cut), 1);
    chk("abort.sd_before", 32'(slices_done), 1);
    seen = finish;
    apply(0,0,1,0,0,0,  0);
    seen |= finish;
    apply(0,0,0,0,0,0,  0);
    chk("abort.cut_next", 32'(cut), 0);
    chk("abort.busy_next", 32'(busy), 0);
    chk("abort.sd_held", 32'(slices_done), 1);
    for (int i = 0; i < 10; i++) begin
      seen |= finish;
      apply(0,0,0,0,0,0, 0);
    end
    chk("abort.no_finish", 32'(seen), 0);

    // Timeout: trigger_suc never comes; 3 windows of 20 cycles, then ERR
    slice_num = 5'd1; thickness = 32'd50;
    apply(1,0,0,0,0,0, 0);
    seen = 1'b0; bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      apply(0,0,0,0,0,0, 0);
      bad  |= !trigger;
      seen |= error;
    end
    chk("timeout.trigger_held", 32'(bad), 0);
    chk("timeout.no_early_err", 32'(seen), 0);
    apply(0,0,0,0,0,0, 0);
    chk("timeout.error", 32'(error), 1);
    chk("timeout.busy", 32'(busy), 0);
    chk("timeout.outs", 32'({trigger, move, cut}), 0);
    apply(1,0,0,0,0,0, 0);
    chk("err.still_set", 32'(error), 1);
    apply(0,0,0,0,0,0, 0);
    chk("restart.error", 32'(error), 0);
    chk("restart.trigger", 32'(trigger), 1);

    // Pause for 30 cycles in WAIT_ECHO with valid pulses that must be ignored
    apply(0,0,0,0,1,0, 0);
    apply(0,0,0,0,0,0, 0);
    apply(0,0,0,0,0,0, 0);
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      apply(0,1,0,(i % 3) == 0,(i % 5) == 0,0,123);
      bad |= trigger | move | !busy;
    end
    chk("pause.outs_frozen", 32'(bad), 0);
    apply(0,0,0,1,0,0,900);
    chk("pause.released_ref", 32'(move), 0);
    apply(0,0,0,0,1,0,  0);
    chk("pause.valid_taken", 32'({trigger, move}), 3);
    apply(0,0,0,1,0,0,850);
    apply(0,0,0,0,0,0,  0);
    apply(0,0,0,0,0,0,  0);
    chk("pause.cut_after", 32'(cut), 1);
    apply(0,0,0,0,0,1,  0);
    apply(0,0,0,0,0,0,  0);
    chk("pause.finish", 32'(finish), 1);
    chk("pause.sd", 32'(slices_done), 1);
    apply(0,0,0,0,0,0,  0);
    chk("pause.finish_once", 32'(finish), 0);

    // Asynchronous reset mid-WAIT_ECHO, then start on the first edge after release
    apply(1,0,0,0,0,0,  0);
    apply(0,0,0,0,1,0,  0);
    apply(0,0,0,1,0,0,900);
    apply(0,0,0,0,1,0,  0);
    apply(0,0,0,0,0,0,  0);
    chk("rst.pre_move", 32'(move), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst.async_outs", 32'(outs()), 0);
    chk("rst.async_sd", 32'(slices_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    #1;
    chk("rst.idle_outs", 32'(outs()), 0);
    apply(0,0,0,0,0,0, 0);
    chk("rst.first_start", 32'({trigger, busy}), 3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
